// File: rtl/comparador_serial_nbits.sv
// Bit-serial N-bit magnitude comparator: loads two words, then resolves one bit pair
// per cycle from the MSB down, stopping early at the first differing pair.
module comparador_serial_nbits #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         maior,
   output logic         menor,
   output logic         igual,
   output logic         ocupado,
   output logic         pronto
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   ra_q, ra_d;
   logic [N-1:0]   rb_q, rb_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           maior_q, maior_d;
   logic           menor_q, menor_d;
   logic           igual_q, igual_d;

   // Single-bit compare stage on the current MSBs
   logic maior_bit, menor_bit, igual_bit;
   assign maior_bit = ra_q[N-1] & ~rb_q[N-1];
   assign menor_bit = ~ra_q[N-1] & rb_q[N-1];
   assign igual_bit = ~(ra_q[N-1] ^ rb_q[N-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ra_q    <= '0;
         rb_q    <= '0;
         cnt_q   <= '0;
         maior_q <= 1'b0;
         menor_q <= 1'b0;
         igual_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         cnt_q   <= cnt_d;
         maior_q <= maior_d;
         menor_q <= menor_d;
         igual_q <= igual_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      cnt_d   = cnt_q;
      maior_d = maior_q;
      menor_d = menor_q;
      igual_d = igual_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               cnt_d   = CW'(N - 1);
               maior_d = 1'b0;
               menor_d = 1'b0;
               igual_d = 1'b0;
               state_d = StCmp;
            end
         end
         StCmp: begin
            if (!igual_bit) begin
               maior_d = maior_bit;
               menor_d = menor_bit;
               igual_d = 1'b0;
               state_d = StDone;
            end else if (cnt_q != '0) begin
               ra_d  = ra_q << 1;
               rb_d  = rb_q << 1;
               cnt_d = cnt_q - CW'(1);
            end else begin
               igual_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      ocupado = (state_q == StCmp);
      pronto  = (state_q == StDone);
      maior   = maior_q;
      menor   = menor_q;
      igual   = igual_q;
   end

endmodule
